// File: rtl/sensor_snapshot_buffer.sv
// rtl/sensor_snapshot_buffer.sv - circular snapshot store with indexed readback and optional timed playback
// Optional playback engine is enabled by defining SNAPSHOT_PLAYBACK_EN.
module sensor_snapshot_buffer #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8,
    parameter int PERIOD = 25000000,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              save_req,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_req,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic              play_req,
    input  logic              stop_req,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              load_err,
    output logic              busy,
    output logic [IDX_W:0]    count,
    output logic              overflow,
    output logic [IDX_W-1:0]  play_index
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  rd_addr;
    logic              load_hit;

    // Age 0 is the slot just behind the write pointer; wraps naturally in IDX_W bits.
    assign rd_addr  = wr_ptr - IDX_W'(1) - load_idx;
    assign load_hit = ({1'b0, load_idx} < count);

    always_ff @(posedge clock) begin
        if (save_req && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (save_req) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (count == FULL) begin
                overflow <= 1'b1;
            end else begin
                count <= count + (IDX_W+1)'(1);
            end
        end
    end

`ifdef SNAPSHOT_PLAYBACK_EN
    localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] play_start;
    logic [IDX_W:0]   play_len;
    logic [IDX_W-1:0] play_next;
    logic [TMR_W-1:0] timer;
    logic             play_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            load_data  <= '0;
            load_valid <= 1'b0;
            load_err   <= 1'b0;
            busy       <= 1'b0;
            play_index <= '0;
            play_start <= '0;
            play_len   <= '0;
            play_next  <= '0;
            timer      <= '0;
            play_last  <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            load_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_req) begin
                        if (load_hit) begin
                            load_data  <= mem[rd_addr];
                            load_valid <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (play_req && count != '0) begin
                        // Oldest slot; when full, wr_ptr already points at it.
                        play_start <= wr_ptr - count[IDX_W-1:0];
                        play_len   <= count;
                        play_next  <= '0;
                        timer      <= '0;
                        play_last  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= PLAY;
                    end
                end
                PLAY: begin
                    if (stop_req || play_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (timer == '0) begin
                        load_data  <= mem[play_start + play_next];
                        load_valid <= 1'b1;
                        play_index <= play_next;
                        play_next  <= play_next + IDX_W'(1);
                        play_last  <= ({1'b0, play_next} == play_len - (IDX_W+1)'(1));
                        timer      <= TMR_W'(PERIOD - 1);
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    logic unused_play_inputs;
    assign unused_play_inputs = &{1'b0, play_req, stop_req};
    assign busy       = 1'b0;
    assign play_index = '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            load_data  <= '0;
            load_valid <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            load_err   <= 1'b0;
            if (load_req) begin
                if (load_hit) begin
                    load_data  <= mem[rd_addr];
                    load_valid <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sensor_snapshot_buffer.sv
// tb/tb_sensor_snapshot_buffer.sv - directed self-checking bench for sensor_snapshot_buffer
module tb_sensor_snapshot_buffer;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 8;
    localparam int PERIOD = 4;
    localparam int IDX_W  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              save_req = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              load_req = 1'b0;
    logic [IDX_W-1:0]  load_idx = '0;
    logic              play_req = 1'b0;
    logic              stop_req = 1'b0;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_err;
    logic              busy;
    logic [IDX_W:0]    count;
    logic              overflow;
    logic [IDX_W-1:0]  play_index;

    int passed = 0;
    int total  = 0;

    sensor_snapshot_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .PERIOD(PERIOD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .save_req  (save_req),
        .data_in   (data_in),
        .load_req  (load_req),
        .load_idx  (load_idx),
        .play_req  (play_req),
        .stop_req  (stop_req),
        .load_data (load_data),
        .load_valid(load_valid),
        .load_err  (load_err),
        .busy      (busy),
        .count     (count),
        .overflow  (overflow),
        .play_index(play_index)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic save(input logic [DATA_W-1:0] d);
        save_req = 1'b1;
        data_in  = d;
        tick();
        save_req = 1'b0;
    endtask

    task automatic load(input logic [IDX_W-1:0] idx);
        load_req = 1'b1;
        load_idx = idx;
        tick();
        load_req = 1'b0;
    endtask

    initial begin
        int nvalid;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_load_data", 32'(load_data), 0);
        check("rst_load_valid", 32'(load_valid), 0);
        check("rst_load_err", 32'(load_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_play_index", 32'(play_index), 0);

        load(3'd0);
        check("empty_err", 32'(load_err), 1);
        check("empty_valid", 32'(load_valid), 0);
        tick();
        check("empty_err_pulse", 32'(load_err), 0);

        save(24'h000001);
        save(24'h000002);
        save(24'h000003);
        check("count3", 32'(count), 3);

        load(3'd0);
        check("ld0_valid", 32'(load_valid), 1);
        check("ld0_data", 32'(load_data), 32'h3);
        tick();
        check("ld0_pulse", 32'(load_valid), 0);
        load(3'd2);
        check("ld2_valid", 32'(load_valid), 1);
        check("ld2_data", 32'(load_data), 32'h1);
        load(3'd3);
        check("ld3_err", 32'(load_err), 1);
        check("ld3_valid", 32'(load_valid), 0);
        check("ld3_data_hold", 32'(load_data), 32'h1);

`ifdef SNAPSHOT_PLAYBACK_EN
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        check("play_busy0", 32'(busy), 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("play_valid_c%0d", k), 32'(load_valid),
                  (k == 1 || k == 5 || k == 9) ? 32'd1 : 32'd0);
            check($sformatf("play_busy_c%0d", k), 32'(busy), (k < 10) ? 32'd1 : 32'd0);
            if (k == 1 || k == 5 || k == 9) begin
                check($sformatf("play_data_c%0d", k), 32'(load_data), 32'((k - 1) / 4 + 1));
                check($sformatf("play_idx_c%0d", k), 32'(play_index), 32'((k - 1) / 4));
            end
        end

        nvalid = 0;
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) stop_req = 1'b1;
            tick();
            stop_req = 1'b0;
            if (load_valid) nvalid++;
            if (k == 4) check("stop_busy", 32'(busy), 0);
        end
        check("stop_emissions", 32'(nvalid), 1);
`else
        nvalid = 0;
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        check("noplay_busy", 32'(busy), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (load_valid) nvalid++;
        end
        check("noplay_valid", 32'(nvalid), 0);
        check("noplay_busy_end", 32'(busy), 0);
`endif

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            save(24'(32'h10 + i));
        end
        check("ovf_count", 32'(count), 8);
        check("ovf_flag", 32'(overflow), 1);
        load(3'd7);
        check("ovf_ld7", 32'(load_data), 32'h11);
        load(3'd0);
        check("ovf_ld0", 32'(load_data), 32'h18);

        save(24'h000055);
        save_req = 1'b1;
        data_in  = 24'h0000AA;
        load_req = 1'b1;
        load_idx = 3'd0;
        tick();
        save_req = 1'b0;
        load_req = 1'b0;
        check("same_cycle_data", 32'(load_data), 32'h55);
        check("same_cycle_valid", 32'(load_valid), 1);
        load(3'd0);
        check("after_same_data", 32'(load_data), 32'hAA);
        check("ovf_sticky", 32'(overflow), 1);

`ifdef SNAPSHOT_PLAYBACK_EN
        nvalid = 0;
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) check("rstplay_first", 32'(load_data), 32'h13);
            if (load_valid) nvalid++;
        end
        check("rstplay_two", 32'(nvalid), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstplay_valid", 32'(load_valid), 0);
        check("rstplay_data", 32'(load_data), 0);
        check("rstplay_busy", 32'(busy), 0);
        check("rstplay_count", 32'(count), 0);
        check("rstplay_ovf", 32'(overflow), 0);
        check("rstplay_idx", 32'(play_index), 0);
        nvalid = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (load_valid) nvalid++;
        end
        check("rstplay_quiet", 32'(nvalid), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
